// File: rtl/ca_seek_sequencer.sv
// Seek sequencer: resets the C/A initializer to a requested PRN/shift,
// waits for seek completion, then hands the captured state to a channel.
module ca_seek_sequencer #(
  parameter int PRN_WIDTH      = 5,
  parameter int CS_WIDTH       = 14,
  parameter int MAX_CODE_SHIFT = 16367,
  parameter int ACC_WIDTH      = 25,
  parameter int HIST_WIDTH     = 2,
  parameter int CH_WIDTH       = 3,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16400
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PRN_WIDTH-1:0]  req_prn,
  input  logic [CS_WIDTH-1:0]   req_target,
  input  logic [CH_WIDTH-1:0]   req_channel,
  input  logic                  abort,
  output logic                  init_reset,
  output logic [PRN_WIDTH-1:0]  init_prn,
  output logic [CS_WIDTH-1:0]   init_target,
  input  logic                  seek_complete,
  input  logic [ACC_WIDTH-1:0]  in_ca_clk_acc,
  input  logic                  in_ca_clk_hist,
  input  logic [HIST_WIDTH-1:0] in_prompt_hist,
  input  logic [HIST_WIDTH-1:0] in_late_hist,
  input  logic [9:0]            in_g1,
  input  logic [9:0]            in_g2,
  output logic                  load_valid,
  input  logic                  load_ready,
  output logic [CH_WIDTH-1:0]   load_channel,
  output logic [ACC_WIDTH-1:0]  load_ca_clk_acc,
  output logic                  load_ca_clk_hist,
  output logic [HIST_WIDTH-1:0] load_prompt_hist,
  output logic [HIST_WIDTH-1:0] load_late_hist,
  output logic [9:0]            load_g1,
  output logic [9:0]            load_g2,
  output logic                  busy,
  output logic                  done,
  output logic                  seek_error
);

  localparam int WD_W = 15;
  localparam logic [CS_WIDTH-1:0] MAX_CS =
    CS_WIDTH'(MAX_CODE_SHIFT);
  localparam logic [WD_W-1:0] SETTLE_LAST =
    WD_W'(SETTLE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT =
    WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_SEEK, S_LOAD
  } state_t;

  state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CH_WIDTH-1:0] ch_q, ch_d;
  logic req_ready_q, req_ready_d;
  logic init_reset_q, init_reset_d;
  logic [PRN_WIDTH-1:0] prn_q, prn_d;
  logic [CS_WIDTH-1:0] tgt_q, tgt_d;
  logic load_valid_q, load_valid_d;
  logic [CH_WIDTH-1:0] lch_q, lch_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic clkh_q, clkh_d;
  logic [HIST_WIDTH-1:0] ph_q, ph_d;
  logic [HIST_WIDTH-1:0] lh_q, lh_d;
  logic [9:0] g1_q, g1_d;
  logic [9:0] g2_q, g2_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic accept, bad_tgt, hshake, capture, timeout;

  assign accept  = (state_q == S_IDLE) && req_valid
                   && req_ready_q;
  assign bad_tgt = req_target > MAX_CS;
  assign hshake  = load_valid_q && load_ready;
  assign capture = (state_q == S_SEEK) && !abort
                   && seek_complete;
  assign timeout = wd_q == WD_LIMIT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wd_q         <= '0;
      ch_q         <= '0;
      req_ready_q  <= 1'b1;
      init_reset_q <= 1'b1;
      prn_q        <= '0;
      tgt_q        <= '0;
      load_valid_q <= 1'b0;
      lch_q        <= '0;
      acc_q        <= '0;
      clkh_q       <= 1'b0;
      ph_q         <= '0;
      lh_q         <= '0;
      g1_q         <= '0;
      g2_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      ch_q         <= ch_d;
      req_ready_q  <= req_ready_d;
      init_reset_q <= init_reset_d;
      prn_q        <= prn_d;
      tgt_q        <= tgt_d;
      load_valid_q <= load_valid_d;
      lch_q        <= lch_d;
      acc_q        <= acc_d;
      clkh_q       <= clkh_d;
      ph_q         <= ph_d;
      lh_q         <= lh_d;
      g1_q         <= g1_d;
      g2_q         <= g2_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // abort wins everywhere except over a load handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept && !bad_tgt) state_d = S_RST;
      S_RST:
        state_d = abort ? S_IDLE : S_SETTLE;
      S_SETTLE:
        if (abort) state_d = S_IDLE;
        else if (wd_q == SETTLE_LAST) state_d = S_SEEK;
      S_SEEK:
        if (abort) state_d = S_IDLE;
        else if (seek_complete) state_d = S_LOAD;
        else if (timeout) state_d = S_IDLE;
      S_LOAD:
        if (hshake || abort) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wd_d = wd_q;
    unique case (state_q)
      S_RST:    wd_d = '0;
      S_SETTLE: wd_d = wd_q + WD_W'(1);
      S_SEEK:   wd_d = wd_q + WD_W'(1);
      default:  wd_d = wd_q;
    endcase
    done_d = (state_q == S_LOAD) && hshake;
    err_d  = (accept && bad_tgt)
             || ((state_q == S_SEEK) && !abort
                 && !seek_complete && timeout);
    req_ready_d  = (state_d == S_IDLE) && !done_d && !err_d;
    init_reset_d = state_d == S_RST;
    load_valid_d = state_d == S_LOAD;
    busy_d       = state_d != S_IDLE;
    prn_d = prn_q;
    tgt_d = tgt_q;
    ch_d  = ch_q;
    if (accept && !bad_tgt) begin
      prn_d = req_prn;
      tgt_d = req_target;
      ch_d  = req_channel;
    end
    lch_d  = lch_q;
    acc_d  = acc_q;
    clkh_d = clkh_q;
    ph_d   = ph_q;
    lh_d   = lh_q;
    g1_d   = g1_q;
    g2_d   = g2_q;
    if (capture) begin
      lch_d  = ch_q;
      acc_d  = in_ca_clk_acc;
      clkh_d = in_ca_clk_hist;
      ph_d   = in_prompt_hist;
      lh_d   = in_late_hist;
      g1_d   = in_g1;
      g2_d   = in_g2;
    end
  end

  assign req_ready        = req_ready_q;
  assign init_reset       = init_reset_q;
  assign init_prn         = prn_q;
  assign init_target      = tgt_q;
  assign load_valid       = load_valid_q;
  assign load_channel     = lch_q;
  assign load_ca_clk_acc  = acc_q;
  assign load_ca_clk_hist = clkh_q;
  assign load_prompt_hist = ph_q;
  assign load_late_hist   = lh_q;
  assign load_g1          = g1_q;
  assign load_g2          = g2_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign seek_error       = err_q;

endmodule

// File: tb/tb_ca_seek_sequencer.sv
// Bench for ca_seek_sequencer: directed table, random transactions
// against a timeline model, plus watchdog and async-reset sequences.
module tb_ca_seek_sequencer;

  localparam int TIMEOUT = 16400;

  logic clk = 1'b0;
  logic reset_n;
  logic req_valid, req_ready;
  logic [4:0] req_prn;
  logic [13:0] req_target;
  logic [2:0] req_channel;
  logic abort, init_reset;
  logic [4:0] init_prn;
  logic [13:0] init_target;
  logic seek_complete;
  logic [24:0] in_ca_clk_acc;
  logic in_ca_clk_hist;
  logic [1:0] in_prompt_hist, in_late_hist;
  logic [9:0] in_g1, in_g2;
  logic load_valid, load_ready;
  logic [2:0] load_channel;
  logic [24:0] load_ca_clk_acc;
  logic load_ca_clk_hist;
  logic [1:0] load_prompt_hist, load_late_hist;
  logic [9:0] load_g1, load_g2;
  logic busy, done, seek_error;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ca_seek_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_prn(req_prn), .req_target(req_target),
    .req_channel(req_channel), .abort(abort),
    .init_reset(init_reset), .init_prn(init_prn),
    .init_target(init_target),
    .seek_complete(seek_complete),
    .in_ca_clk_acc(in_ca_clk_acc),
    .in_ca_clk_hist(in_ca_clk_hist),
    .in_prompt_hist(in_prompt_hist),
    .in_late_hist(in_late_hist),
    .in_g1(in_g1), .in_g2(in_g2),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_channel(load_channel),
    .load_ca_clk_acc(load_ca_clk_acc),
    .load_ca_clk_hist(load_ca_clk_hist),
    .load_prompt_hist(load_prompt_hist),
    .load_late_hist(load_late_hist),
    .load_g1(load_g1), .load_g2(load_g2),
    .busy(busy), .done(done), .seek_error(seek_error)
  );

  typedef struct {
    int prn; int tgt; int ch;
    int sc; int rd; int ab;
    int e_done; int e_edge; int e_lv; int e_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0;
    abort = 0;
    seek_complete = 0;
    load_ready = 0;
  endtask

  function automatic longint state_word();
    return {load_ca_clk_acc, load_ca_clk_hist,
            load_prompt_hist, load_late_hist,
            load_g1, load_g2};
  endfunction

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 10 && !req_ready; i++) tick();
    chk({nm, ".ready"}, req_ready, 1);
  endtask

  // cycle k = inputs applied before edge k; edge 0 accepts
  task automatic run_txn(input vec_t v, input string nm);
    int cap, hs, win;
    int n_done, d_edge, n_lv, n_err, n_ir, lv_bad;
    longint exp_st;
    logic [24:0] a;
    logic h;
    logic [1:0] p, l;
    logic [9:0] x1, x2;
    cap = (v.sc < 4) ? 4 : v.sc;
    hs = cap + 1 + v.rd;
    win = v.e_err ? 3 : hs + 3;
    n_done = 0; d_edge = -1; n_lv = 0;
    n_err = 0; n_ir = 0; lv_bad = 0;
    exp_st = 0;
    for (int k = 0; k <= win; k++) begin
      req_valid = (k == 0);
      req_prn = 5'(v.prn);
      req_target = 14'(v.tgt);
      req_channel = 3'(v.ch);
      abort = (k == v.ab);
      seek_complete = (k >= v.sc) && (k <= cap);
      load_ready = (k >= hs) && (k <= hs + 1);
      a = 25'($urandom); h = 1'($urandom);
      p = 2'($urandom); l = 2'($urandom);
      x1 = 10'($urandom); x2 = 10'($urandom);
      in_ca_clk_acc = a; in_ca_clk_hist = h;
      in_prompt_hist = p; in_late_hist = l;
      in_g1 = x1; in_g2 = x2;
      if (k == cap) exp_st = {a, h, p, l, x1, x2};
      tick();
      if (done) begin n_done++; d_edge = k; end
      if (seek_error) n_err++;
      if (init_reset) n_ir++;
      if (load_valid) begin
        n_lv++;
        if (state_word() != exp_st) lv_bad++;
        if (load_channel != 3'(v.ch)) lv_bad++;
      end
      if (k == 0) begin
        chk({nm, ".busy0"}, busy, !v.e_err);
        chk({nm, ".ready0"}, req_ready, 0);
        if (!v.e_err) begin
          chk({nm, ".iprn"}, init_prn, v.prn);
          chk({nm, ".itgt"}, init_target, v.tgt);
        end
      end
      if (v.e_err && k == 1)
        chk({nm, ".ready_after_err"}, req_ready, 1);
      if (v.e_done && k == hs + 1)
        chk({nm, ".ready_after_done"}, req_ready, 1);
    end
    idle_inputs();
    chk({nm, ".done_cnt"}, n_done, v.e_done);
    if (v.e_done) chk({nm, ".done_edge"}, d_edge, v.e_edge);
    chk({nm, ".err_cnt"}, n_err, v.e_err);
    chk({nm, ".lv_cycles"}, n_lv, v.e_lv);
    chk({nm, ".load_data"}, lv_bad, 0);
    chk({nm, ".init_rst"}, n_ir, v.e_err ? 0 : 1);
    chk({nm, ".busy_end"}, busy, 0);
    wait_ready(nm);
  endtask

  // transaction-level outcome from the request timeline
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int cap, hs;
    logic dropped;
    r = v;
    cap = (v.sc < 4) ? 4 : v.sc;
    hs = cap + 1 + v.rd;
    if (v.tgt > 16367) begin
      r.e_done = 0; r.e_edge = 0; r.e_lv = 0; r.e_err = 1;
    end else begin
      dropped = (v.ab >= 1) && (v.ab < hs);
      r.e_err = 0;
      r.e_done = dropped ? 0 : 1;
      r.e_edge = hs;
      if (!dropped) r.e_lv = hs - cap;
      else r.e_lv = (v.ab > cap) ? v.ab - cap : 0;
    end
    return r;
  endfunction

  initial begin
    vec_t v;
    int e_edge, n_lv;
    reset_n = 0;
    idle_inputs();
    req_prn = 0; req_target = 0; req_channel = 0;
    in_ca_clk_acc = 0; in_ca_clk_hist = 0;
    in_prompt_hist = 0; in_late_hist = 0;
    in_g1 = 0; in_g2 = 0;

    tbl[0]  = '{1, 100, 5, 4, 0, -1, 1, 5, 1, 0};
    tbl[1]  = '{2, 16368, 1, 4, 0, -1, 0, 0, 0, 1};
    tbl[2]  = '{3, 16367, 7, 2, 3, -1, 1, 8, 4, 0};
    tbl[3]  = '{4, 0, 2, 9, 50, -1, 1, 60, 51, 0};
    tbl[4]  = '{5, 200, 3, 8, 0, 6, 0, 0, 0, 0};
    tbl[5]  = '{6, 300, 4, 5, 2, 8, 1, 8, 3, 0};
    tbl[6]  = '{7, 400, 6, 4, 4, 7, 0, 0, 3, 0};
    tbl[7]  = '{8, 500, 0, 4, 1, 0, 1, 6, 2, 0};
    tbl[8]  = '{9, 600, 1, 4, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{10, 700, 2, 6, 0, 6, 0, 0, 0, 0};
    tbl[10] = '{31, 16383, 5, 4, 0, -1, 0, 0, 0, 1};

    #12;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.init_reset", init_reset, 1);
    chk("rst.load_valid", load_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.seek_error", seek_error, 0);
    chk("rst.load_g1", load_g1, 0);
    @(negedge clk);
    reset_n = 1;
    tick();
    chk("post_rst.init_reset", init_reset, 0);

    for (int i = 0; i < 11; i++)
      run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.prn = $urandom_range(1, 31);
      v.ch = $urandom_range(0, 7);
      v.tgt = ($urandom_range(0, 7) == 0)
              ? $urandom_range(16368, 16383)
              : $urandom_range(0, 16367);
      v.sc = $urandom_range(2, 12);
      v.rd = $urandom_range(0, 6);
      v.ab = ($urandom_range(0, 1) == 0) ? -1
             : $urandom_range(0, ((v.sc < 4) ? 4 : v.sc)
                                  + v.rd + 3);
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    // watchdog: no completion ever arrives
    req_valid = 1; req_prn = 3; req_target = 500;
    req_channel = 2;
    e_edge = -1; n_lv = 0;
    for (int k = 0; k < 17000; k++) begin
      tick();
      req_valid = 0;
      if (load_valid) n_lv++;
      if (seek_error) begin e_edge = k; break; end
    end
    chk("wd.err_edge", e_edge, 1 + TIMEOUT + 1);
    chk("wd.no_load", n_lv, 0);
    chk("wd.busy", busy, 0);
    tick();
    chk("wd.err_single", seek_error, 0);
    chk("wd.ready", req_ready, 1);

    // asynchronous reset while seeking
    req_valid = 1; req_prn = 9; req_target = 1234;
    req_channel = 6;
    tick();
    req_valid = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("ar.busy_before", busy, 1);
    #2 reset_n = 0;
    #1;
    chk("ar.req_ready", req_ready, 1);
    chk("ar.init_reset", init_reset, 1);
    chk("ar.busy", busy, 0);
    chk("ar.load_valid", load_valid, 0);
    chk("ar.init_prn", init_prn, 0);
    chk("ar.flags", {done, seek_error}, 0);
    #2 reset_n = 1;
    tick();
    chk("ar.flags_after", {done, seek_error}, 0);
    run_txn(tbl[0], "ar.resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
